// File: rtl/tone_period_meter.sv
// Measures the rising-edge period of an asynchronous tone and tracks lock and loss of the tone.
// Optional feature: define TONE_MATCH_EN to drive tone_match from a period tolerance comparator.
module tone_period_meter #(
  parameter int unsigned CLK_FREQ          = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES    = CLK_FREQ / 10,
  parameter int unsigned MIN_PERIOD_CYCLES = 1000,
  parameter int unsigned TARGET_PERIOD     = CLK_FREQ / 1000,
  parameter int unsigned TOLERANCE         = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [31:0] period_out,
  output logic        period_valid,
  output logic        tone_present,
  output logic        tone_lost,
  output logic        tone_match
);

  localparam logic [31:0] Timeout   = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] MinPeriod = 32'(MIN_PERIOD_CYCLES);

  // A period that can never be accepted, or a target beyond the timeout, is a configuration error.
  if (MIN_PERIOD_CYCLES > TIMEOUT_CYCLES ||
      TARGET_PERIOD + TOLERANCE > TIMEOUT_CYCLES) begin : g_cfg_check
    $error("tone_period_meter: period limits must fit below TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q, rise_q;
  logic [31:0] cnt_q, cnt_d, period_d;
  logic        period_valid_d, tone_lost_d;
  logic        accept, timeout;

  always_comb begin
    accept         = rise_q && ((state_q == StIdle) || (cnt_q >= MinPeriod));
    // An accepted edge wins over a timeout landing in the same cycle.
    timeout        = (state_q != StIdle) && (cnt_q >= Timeout) && !accept;
    state_d        = state_q;
    cnt_d          = (cnt_q >= Timeout) ? Timeout : cnt_q + 32'd1;
    period_d       = period_out;
    period_valid_d = 1'b0;
    tone_lost_d    = 1'b0;
    if (accept) begin
      cnt_d = 32'd1;
      if (state_q == StIdle) begin
        state_d = StArmed;
      end else begin
        state_d        = StLocked;
        period_d       = cnt_q;
        period_valid_d = 1'b1;
      end
    end else if (timeout) begin
      state_d     = StIdle;
      tone_lost_d = 1'b1;
    end
  end

  // rise_q adds one stage after edge detection so the FSM acts three clocks after first sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      rise_q       <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= 32'd0;
      period_out   <= 32'd0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
      tone_lost    <= 1'b0;
    end else begin
      s1_q         <= tone_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      rise_q       <= s2_q & ~s3_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_out   <= period_d;
      period_valid <= period_valid_d;
      tone_present <= (state_d == StLocked);
      tone_lost    <= tone_lost_d;
    end
  end

`ifdef TONE_MATCH_EN
  localparam logic [31:0] Target = 32'(TARGET_PERIOD);
  localparam logic [31:0] Tol    = 32'(TOLERANCE);

  logic [31:0] deviation;
  logic        tone_match_d;

  always_comb begin
    deviation    = (cnt_q >= Target) ? cnt_q - Target : Target - cnt_q;
    tone_match_d = tone_match;
    if (period_valid_d) begin
      tone_match_d = (deviation <= Tol);
    end else if (tone_lost_d) begin
      tone_match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_match <= 1'b0;
    end else begin
      tone_match <= tone_match_d;
    end
  end
`else
  assign tone_match = 1'b0;
`endif

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomised bench for tone_period_meter against a timestamp-based reference model.
module tb_tone_period_meter;

  localparam int unsigned ClkFreq   = 20_000;
  localparam int unsigned Timeout   = 2000;
  localparam int unsigned MinPeriod = 300;
  localparam int unsigned Target    = 500;
  localparam int unsigned Tol       = 5;
  localparam int          HistLen   = 1 << 17;

  logic        clk;
  logic        rst_n;
  logic        tone_in;
  logic [31:0] period_out;
  logic        period_valid;
  logic        tone_present;
  logic        tone_lost;
  logic        tone_match;

  tone_period_meter #(
    .CLK_FREQ         (ClkFreq),
    .TIMEOUT_CYCLES   (Timeout),
    .MIN_PERIOD_CYCLES(MinPeriod),
    .TARGET_PERIOD    (Target),
    .TOLERANCE        (Tol)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .tone_present(tone_present),
    .tone_lost   (tone_lost),
    .tone_match  (tone_match)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: tone level seen by the first synchroniser at each clock, plus the time of
  // the last accepted rising edge and a coarse idle/armed/locked mode.
  bit          s1h [HistLen];
  int          mode     = 0;
  int          last_acc = 0;
  logic [31:0] m_period = '0;
  bit          m_valid, m_present, m_lost, m_match;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit in_reset, input bit t);
    bit rise;
    int gap;
    int dev;
    s1h[cyc] = in_reset ? 1'b0 : t;
    m_valid  = 1'b0;
    m_lost   = 1'b0;
    if (in_reset) begin
      mode      = 0;
      m_period  = '0;
      m_present = 1'b0;
      m_match   = 1'b0;
    end else begin
      rise = (cyc >= 4) && s1h[cyc-3] && !s1h[cyc-4];
      gap  = cyc - last_acc;
      if (rise && (mode == 0 || gap >= int'(MinPeriod))) begin
        if (mode != 0) begin
          m_period = 32'(gap);
          m_valid  = 1'b1;
          dev      = (gap > int'(Target)) ? gap - int'(Target) : int'(Target) - gap;
          m_match  = (dev <= int'(Tol));
          mode     = 2;
        end else begin
          mode = 1;
        end
        last_acc = cyc;
      end else if (mode != 0 && gap >= int'(Timeout)) begin
        mode    = 0;
        m_lost  = 1'b1;
        m_match = 1'b0;
      end
      m_present = (mode == 2);
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic tick(input bit t, input bit rn);
    @(negedge clk);
    tone_in = t;
    rst_n   = rn;
    @(posedge clk);
    model_step(!rn, t);
    #1;
    check("period_out", period_out, m_period);
    check("period_valid", 32'(period_valid), 32'(m_valid));
    check("tone_present", 32'(tone_present), 32'(m_present));
    check("tone_lost", 32'(tone_lost), 32'(m_lost));
`ifdef TONE_MATCH_EN
    check("tone_match", 32'(tone_match), 32'(m_match));
`else
    check("tone_match", 32'(tone_match), 32'd0);
`endif
    cyc++;
  endtask

  task automatic wave(input int hi, input int lo);
    repeat (hi) tick(1'b1, 1'b1);
    repeat (lo) tick(1'b0, 1'b1);
  endtask

  initial begin
    int period, hi, lo, kind, a, g;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (4) tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b1);

    // On-target tone, then slightly off-target tone
    repeat (4) wave(250, 250);
    repeat (2) wave(255, 255);
    wave(250, 250);

    // Glitch 200 cycles after an accepted edge, true edge at 500
    wave(100, 100);
    wave(2, 298);
    wave(250, 250);

    // Edge exactly at the timeout, then one cycle too late, then relock
    wave(100, int'(Timeout) - 100);
    wave(100, int'(Timeout) - 99);
    repeat (3) wave(250, 250);

    // Tone disappears long enough to time out
    repeat (3 * Timeout) tick(1'b0, 1'b1);
    repeat (3) wave(250, 250);

    // One-cycle reset while the tone is low, midway through a period
    wave(250, 100);
    tick(1'b0, 1'b0);
    repeat (149) tick(1'b0, 1'b1);
    repeat (3) wave(250, 250);

    for (int i = 0; i < 25; i++) begin
      period = int'($urandom_range(250, 2100));
      hi     = int'($urandom_range(1, period - 1));
      lo     = period - hi;
      kind   = int'($urandom_range(0, 7));
      if (kind == 0 && lo >= 12) begin
        a = int'($urandom_range(3, lo - 8));
        g = int'($urandom_range(1, 3));
        repeat (hi) tick(1'b1, 1'b1);
        repeat (a) tick(1'b0, 1'b1);
        repeat (g) tick(1'b1, 1'b1);
        repeat (lo - a - g) tick(1'b0, 1'b1);
      end else if (kind == 1 && lo >= 12) begin
        repeat (hi) tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        repeat (lo - 6) tick(1'b0, 1'b1);
      end else begin
        wave(hi, lo);
      end
    end

    repeat (10) tick(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_period_meter.md
TONE_PERIOD_METER -- requirements
Module: tone_period_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: system clock rate in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default CLK_FREQ/10: maximum gap between rising edges before the tone counts as lost.
REQ-003 SHALL have parameter MIN_PERIOD_CYCLES, default 1000: rising edges arriving sooner than this are glitches.
REQ-004 SHALL have parameter TARGET_PERIOD, default CLK_FREQ/1000: expected period in cycles (1 kHz tone).
REQ-005 SHALL have parameter TOLERANCE, default 500: allowed deviation from TARGET_PERIOD, in cycles.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port tone_in, input, 1: asynchronous square-wave input, e.g. buzzer loopback or mic comparator.
REQ-009 SHALL have port period_out, output, 32: last measured rising-to-rising period in clk cycles.
REQ-010 SHALL have port period_valid, output, 1: one-cycle pulse when period_out updates.
REQ-011 SHALL have port tone_present, output, 1: high while state is LOCKED.
REQ-012 SHALL have port tone_lost, output, 1: one-cycle pulse on timeout from ARMED or LOCKED.
REQ-013 SHALL have port tone_match, output, 1: measured period is within tolerance (see Configuration).

Function
REQ-014 SHALL synchronise tone_in through two flops (s1, s2); a third flop s3 SHALL hold the previous s2.
REQ-015 SHALL detect a rising edge (edge) when s2=1 and s3=0; falling edges SHALL be ignored.
REQ-016 SHALL keep a 32-bit counter cnt: on an accepted edge cnt <= 1, otherwise cnt <= cnt+1, saturating at TIMEOUT_CYCLES.
REQ-017 SHALL accept an edge only when in IDLE or when cnt >= MIN_PERIOD_CYCLES; a rejected edge SHALL leave cnt, state and all outputs unchanged.
REQ-018 SHALL implement FSM states IDLE, ARMED and LOCKED.
REQ-019 SHALL make these transitions: IDLE to ARMED on accepted edge; ARMED to LOCKED on accepted edge; LOCKED to LOCKED on accepted edge; ARMED or LOCKED to IDLE when cnt reaches TIMEOUT_CYCLES.
REQ-020 SHALL, on an accepted edge in ARMED or LOCKED, register period_out <= cnt and pulse period_valid for exactly one cycle.
REQ-021 SHALL NOT pulse period_valid on the IDLE-to-ARMED edge.
REQ-022 SHALL assert period_valid on the third rising clk edge after the clk edge that first samples tone_in high.
REQ-023 SHALL pulse tone_lost for one cycle on the timeout transition; period_out SHALL hold its last value.
REQ-024 SHALL treat an accepted edge in the same cycle as timeout as the edge: no timeout, no tone_lost, normal edge handling.
REQ-025 SHALL make all outputs registered.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, set state=IDLE, cnt=0, s1=s2=s3=0, period_out=0, period_valid=0, tone_present=0, tone_lost=0 and tone_match=0.
REQ-027 SHALL abort any measurement on reset asserted mid-operation, producing no period_valid or tone_lost pulse.
REQ-028 SHALL treat the first rising edge after reset release as the IDLE-to-ARMED edge.

Configuration
REQ-029 SHALL, with macro TONE_MATCH_EN defined, update tone_match together with period_valid as (|period - TARGET_PERIOD| <= TOLERANCE), using unsigned arithmetic with no wrap.
REQ-030 SHALL, with TONE_MATCH_EN defined, clear tone_match on timeout and on reset.
REQ-031 SHALL, with TONE_MATCH_EN undefined, keep the tone_match port present, drive it constant 0, and synthesise no comparator logic.

Verification
REQ-032 SHALL cover 1 kHz square wave (50000-cycle period) -> second rising edge gives period_valid with period_out=50000, tone_present=1, tone_match=1 (macro on).
REQ-033 SHALL cover a period of 51000 cycles -> period_out=51000, tone_match=0 (macro on); tone_match=0 with the macro off for any input.
REQ-034 SHALL cover a glitch pulse 200 cycles after an accepted edge -> ignored, and the next true edge at 50000 gives period_out=50000.
REQ-035 SHALL cover tone_in held low for 5_000_000 cycles after LOCKED -> tone_lost pulses once, state=IDLE, tone_present=0, period_out holds 50000.
REQ-036 SHALL cover rst_n=0 for one cycle midway through a period -> all outputs 0, the next edge gives no period_valid, and the following edge measures correctly.
REQ-037 SHALL cover an edge accepted in the exact cycle cnt reaches TIMEOUT_CYCLES -> no tone_lost, and period_valid with period_out=TIMEOUT_CYCLES.
